// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle instruction sequencer for a small accumulator-less core
//
// Purpose:
//   Moore FSM that walks each instruction through fetch, decode, operand
//   reads, write-back or I/O, and PC increment. It drives the datapath
//   enables and the mux/ALU selects.
//
// Optional feature:
//   CTRL_HALT_EN - when defined, opcode 7 parks the core in state H with
//   halted=1 until reset. When it is undefined, opcode 7 behaves as NOP,
//   H is unreachable and halted is tied to 0.
//
// Parameters:
//   OPW  - opcode width (3..6)
//   SELW - selmux width (2..4); the select values are zero-extended
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset; forces every output to 0
//   opcode   in   [OPW]  opcode from the IR, sampled only in D
//   mem_rdy  in   memory access complete this cycle
//   io_ack   in   output device accepted data this cycle
//   enmem, wrmem, enir, enrop1, enrop2, enrio, enpc
//            out  memory enable/write, IR load, op1/op2 load, IO load, PC inc
//   seloper  out  [2]    ALU op (00 add, 01 sub, 10 and, 11 or)
//   selmux   out  [SELW] address/data mux select
//   halted   out  core stopped
//   state    out  [4]    current state code (debug)

module control_unit #(
    parameter int OPW  = 3,
    parameter int SELW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OPW-1:0]  opcode,
    input  logic            mem_rdy,
    input  logic            io_ack,
    output logic            enmem,
    output logic            wrmem,
    output logic            enir,
    output logic            enrop1,
    output logic            enrop2,
    output logic            enrio,
    output logic            enpc,
    output logic [1:0]      seloper,
    output logic [SELW-1:0] selmux,
    output logic            halted,
    output logic [3:0]      state
);

    typedef enum logic [3:0] {
        ST_F   = 4'd0,
        ST_D   = 4'd1,
        ST_OP1 = 4'd2,
        ST_OP2 = 4'd3,
        ST_WC  = 4'd4,
        ST_GA  = 4'd5,
        ST_GB  = 4'd6,
        ST_OA  = 4'd7,
        ST_PC  = 4'd8,
        ST_H   = 4'd9
    } state_t;

    state_t         state_q, state_d;
    logic [OPW-1:0] op_q, op_d;

    // Zero-extended copies so the decode tables can name opcodes 0..7 and
    // let any wider value fall through to the NOP default.
    logic [7:0] opcode_ext;
    logic [7:0] op_q_ext;

    assign opcode_ext = 8'(opcode);
    assign op_q_ext   = 8'(op_q);

    // Raw state decode, gated by rst below.
    logic            enmem_r, wrmem_r, enir_r, enrop1_r, enrop2_r, enrio_r, enpc_r;
    logic [1:0]      seloper_r;
    logic [SELW-1:0] selmux_r;
    logic            halted_r;
    logic [1:0]      alu_op;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_F;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // ALU operation is taken from the latched opcode, so IR changes after
    // decode cannot disturb an instruction in flight.
    always_comb begin
        alu_op = 2'b00;
        case (op_q_ext)
            8'd0:    alu_op = 2'b00;
            8'd1:    alu_op = 2'b01;
            8'd4:    alu_op = 2'b10;
            8'd5:    alu_op = 2'b11;
            default: alu_op = 2'b00;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            ST_F:   if (mem_rdy) state_d = ST_D;
            ST_D: begin
                op_d = opcode;
                case (opcode_ext)
                    8'd0, 8'd1, 8'd4, 8'd5: state_d = ST_OP1;
                    8'd2:                   state_d = ST_GA;
                    8'd3:                   state_d = ST_OA;
`ifdef CTRL_HALT_EN
                    8'd7:                   state_d = ST_H;
`endif
                    default:                state_d = ST_PC;
                endcase
            end
            ST_OP1: if (mem_rdy) state_d = ST_OP2;
            ST_OP2: if (mem_rdy) state_d = ST_WC;
            ST_WC:  if (mem_rdy) state_d = ST_PC;
            ST_GA:  if (mem_rdy) state_d = ST_GB;
            ST_GB:  if (mem_rdy) state_d = ST_PC;
            ST_OA:  if (io_ack)  state_d = ST_PC;
            ST_PC:  state_d = ST_F;
`ifdef CTRL_HALT_EN
            ST_H:   state_d = ST_H;
`else
            ST_H:   state_d = ST_F;
`endif
            default: state_d = ST_F;
        endcase
    end

    // Moore output decode.
    always_comb begin
        enmem_r   = 1'b0;
        wrmem_r   = 1'b0;
        enir_r    = 1'b0;
        enrop1_r  = 1'b0;
        enrop2_r  = 1'b0;
        enrio_r   = 1'b0;
        enpc_r    = 1'b0;
        seloper_r = 2'b00;
        selmux_r  = '0;
        halted_r  = 1'b0;
        case (state_q)
            ST_F: begin
                enmem_r  = 1'b1;
                enir_r   = 1'b1;
                selmux_r = SELW'(0);
            end
            ST_OP1, ST_GA: begin
                enmem_r  = 1'b1;
                enrop1_r = 1'b1;
                selmux_r = SELW'(1);
            end
            ST_OP2: begin
                enmem_r   = 1'b1;
                enrop2_r  = 1'b1;
                selmux_r  = SELW'(2);
                seloper_r = alu_op;
            end
            ST_WC: begin
                enmem_r   = 1'b1;
                wrmem_r   = 1'b1;
                selmux_r  = SELW'(3);
                seloper_r = alu_op;
            end
            ST_GB: begin
                enmem_r  = 1'b1;
                wrmem_r  = 1'b1;
                selmux_r = SELW'(2);
            end
            ST_OA: begin
                enrio_r  = 1'b1;
                selmux_r = SELW'(1);
            end
            ST_PC: enpc_r = 1'b1;
`ifdef CTRL_HALT_EN
            ST_H:  halted_r = 1'b1;
`endif
            default: ;
        endcase
    end

    // Reset must silence the outputs at once, even though F normally
    // asserts enmem/enir, so the decode is masked combinationally.
    assign enmem   = enmem_r  & ~rst;
    assign wrmem   = wrmem_r  & ~rst;
    assign enir    = enir_r   & ~rst;
    assign enrop1  = enrop1_r & ~rst;
    assign enrop2  = enrop2_r & ~rst;
    assign enrio   = enrio_r  & ~rst;
    assign enpc    = enpc_r   & ~rst;
    assign seloper = rst ? 2'b00 : seloper_r;
    assign selmux  = rst ? '0 : selmux_r;
`ifdef CTRL_HALT_EN
    assign halted  = halted_r & ~rst;
`else
    assign halted  = 1'b0;
`endif
    assign state   = state_q;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed self-checking bench for control_unit

module tb_control_unit;

    localparam int OPW  = 4;
    localparam int SELW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [OPW-1:0]  opcode;
    logic            mem_rdy;
    logic            io_ack;
    logic            enmem, wrmem, enir, enrop1, enrop2, enrio, enpc;
    logic [1:0]      seloper;
    logic [SELW-1:0] selmux;
    logic            halted;
    logic [3:0]      state;
    logic [11:0]     all_outs;

    int total  = 0;
    int passed = 0;

    control_unit #(.OPW(OPW), .SELW(SELW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_rdy(mem_rdy), .io_ack(io_ack),
        .enmem(enmem), .wrmem(wrmem), .enir(enir), .enrop1(enrop1), .enrop2(enrop2),
        .enrio(enrio), .enpc(enpc), .seloper(seloper), .selmux(selmux),
        .halted(halted), .state(state)
    );

    assign all_outs = {enmem, wrmem, enir, enrop1, enrop2, enrio, enpc, seloper, selmux, halted};

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; opcode = '0; mem_rdy = 1'b0; io_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (state !== 4'd0) $display("FAIL reset_state[%0d] got %0d want 0", i, state); else passed++;
            total++; if (all_outs !== 12'd0) $display("FAIL reset_outs[%0d] got %h want 000", i, all_outs); else passed++;
        end
        rst = 1'b0;
        #1;
        total++; if (enmem !== 1'b1 || enir !== 1'b1) $display("FAIL release_fetch got enmem=%b enir=%b want 1 1", enmem, enir); else passed++;
        total++; if (state !== 4'd0) $display("FAIL release_state got %0d want 0", state); else passed++;
    endtask

    task automatic test_sum();
        int   exp_st[7];
        logic exp_mem[7];
        logic exp_ir[7];
        logic exp_pc[7];
        int   exp_mux[7];
        exp_st  = '{0, 1, 2, 3, 4, 8, 0};
        exp_mem = '{1, 0, 1, 1, 1, 0, 1};
        exp_ir  = '{1, 0, 0, 0, 0, 0, 1};
        exp_pc  = '{0, 0, 0, 0, 0, 1, 0};
        exp_mux = '{0, 0, 1, 2, 3, 0, 0};
        opcode = 4'd0; mem_rdy = 1'b1; io_ack = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            total++; if (state !== 4'(exp_st[i])) $display("FAIL sum_state[%0d] got %0d want %0d", i, state, exp_st[i]); else passed++;
            total++; if (enmem !== exp_mem[i]) $display("FAIL sum_enmem[%0d] got %b want %b", i, enmem, exp_mem[i]); else passed++;
            total++; if (enir !== exp_ir[i]) $display("FAIL sum_enir[%0d] got %b want %b", i, enir, exp_ir[i]); else passed++;
            total++; if (enpc !== exp_pc[i]) $display("FAIL sum_enpc[%0d] got %b want %b", i, enpc, exp_pc[i]); else passed++;
            total++; if (selmux !== SELW'(exp_mux[i])) $display("FAIL sum_selmux[%0d] got %0d want %0d", i, selmux, exp_mux[i]); else passed++;
            total++; if (seloper !== 2'b00) $display("FAIL sum_seloper[%0d] got %b want 00", i, seloper); else passed++;
        end
    endtask

    task automatic test_res_stall();
        int   exp_st[10];
        logic rdy_after[10];
        logic exp_op2[10];
        logic exp_wr[10];
        logic [1:0] exp_sel[10];
        exp_st    = '{0, 1, 2, 3, 3, 3, 3, 4, 8, 0};
        rdy_after = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1};
        exp_op2   = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 0};
        exp_wr    = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        exp_sel   = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
        opcode = 4'd1;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            total++; if (state !== 4'(exp_st[i])) $display("FAIL res_state[%0d] got %0d want %0d", i, state, exp_st[i]); else passed++;
            total++; if (enrop2 !== exp_op2[i]) $display("FAIL res_enrop2[%0d] got %b want %b", i, enrop2, exp_op2[i]); else passed++;
            total++; if (wrmem !== exp_wr[i]) $display("FAIL res_wrmem[%0d] got %b want %b", i, wrmem, exp_wr[i]); else passed++;
            total++; if (seloper !== exp_sel[i]) $display("FAIL res_seloper[%0d] got %b want %b", i, seloper, exp_sel[i]); else passed++;
            mem_rdy = rdy_after[i];
            // IR now holds AND; the instruction in flight must stay RES.
            if (i == 2) opcode = 4'd4;
        end
    endtask

    task automatic test_out();
        int   exp_st[7];
        logic ack_after[7];
        logic exp_rio[7];
        logic exp_mem[7];
        logic exp_pc[7];
        exp_st    = '{0, 1, 7, 7, 7, 8, 0};
        ack_after = '{0, 0, 0, 0, 1, 0, 0};
        exp_rio   = '{0, 0, 1, 1, 1, 0, 0};
        exp_mem   = '{1, 0, 0, 0, 0, 0, 1};
        exp_pc    = '{0, 0, 0, 0, 0, 1, 0};
        opcode = 4'd3; mem_rdy = 1'b1; io_ack = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            total++; if (state !== 4'(exp_st[i])) $display("FAIL out_state[%0d] got %0d want %0d", i, state, exp_st[i]); else passed++;
            total++; if (enrio !== exp_rio[i]) $display("FAIL out_enrio[%0d] got %b want %b", i, enrio, exp_rio[i]); else passed++;
            total++; if (enmem !== exp_mem[i]) $display("FAIL out_enmem[%0d] got %b want %b", i, enmem, exp_mem[i]); else passed++;
            total++; if (enpc !== exp_pc[i]) $display("FAIL out_enpc[%0d] got %b want %b", i, enpc, exp_pc[i]); else passed++;
            io_ack = ack_after[i];
        end
    endtask

    task automatic test_mov();
        int   exp_st[6];
        logic exp_op1[6];
        logic exp_wr[6];
        int   exp_mux[6];
        exp_st  = '{0, 1, 5, 6, 8, 0};
        exp_op1 = '{0, 0, 1, 0, 0, 0};
        exp_wr  = '{0, 0, 0, 1, 0, 0};
        exp_mux = '{0, 0, 1, 2, 0, 0};
        opcode = 4'd2; mem_rdy = 1'b1; io_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            total++; if (state !== 4'(exp_st[i])) $display("FAIL mov_state[%0d] got %0d want %0d", i, state, exp_st[i]); else passed++;
            total++; if (enrop1 !== exp_op1[i]) $display("FAIL mov_enrop1[%0d] got %b want %b", i, enrop1, exp_op1[i]); else passed++;
            total++; if (wrmem !== exp_wr[i]) $display("FAIL mov_wrmem[%0d] got %b want %b", i, wrmem, exp_wr[i]); else passed++;
            total++; if (selmux !== SELW'(exp_mux[i])) $display("FAIL mov_selmux[%0d] got %0d want %0d", i, selmux, exp_mux[i]); else passed++;
        end
    endtask

    // Opcodes 6 and 9 both take the short NOP path.
    task automatic test_nop(input logic [OPW-1:0] op);
        int   exp_st[4];
        logic exp_mem[4];
        logic exp_pc[4];
        exp_st  = '{0, 1, 8, 0};
        exp_mem = '{1, 0, 0, 1};
        exp_pc  = '{0, 0, 1, 0};
        opcode = op; mem_rdy = 1'b1; io_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            total++; if (state !== 4'(exp_st[i])) $display("FAIL nop%0d_state[%0d] got %0d want %0d", op, i, state, exp_st[i]); else passed++;
            total++; if (enmem !== exp_mem[i]) $display("FAIL nop%0d_enmem[%0d] got %b want %b", op, i, enmem, exp_mem[i]); else passed++;
            total++; if (enpc !== exp_pc[i]) $display("FAIL nop%0d_enpc[%0d] got %b want %b", op, i, enpc, exp_pc[i]); else passed++;
        end
    endtask

    task automatic test_halt();
`ifdef CTRL_HALT_EN
        opcode = 4'd7; mem_rdy = 1'b1; io_ack = 1'b0;
        @(negedge clk);
        total++; if (state !== 4'd1) $display("FAIL halt_decode got %0d want 1", state); else passed++;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            total++; if (state !== 4'd9) $display("FAIL halt_state[%0d] got %0d want 9", i, state); else passed++;
            total++; if (halted !== 1'b1) $display("FAIL halt_flag[%0d] got %b want 1", i, halted); else passed++;
            total++; if (all_outs[11:5] !== 7'd0) $display("FAIL halt_enables[%0d] got %b want 0000000", i, all_outs[11:5]); else passed++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (state !== 4'd0 || halted !== 1'b0) $display("FAIL halt_exit got state=%0d halted=%b want 0 0", state, halted); else passed++;
`else
        int exp_st[4];
        exp_st = '{0, 1, 8, 0};
        opcode = 4'd7; mem_rdy = 1'b1; io_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            total++; if (state !== 4'(exp_st[i])) $display("FAIL halt_as_nop_state[%0d] got %0d want %0d", i, state, exp_st[i]); else passed++;
            total++; if (halted !== 1'b0) $display("FAIL halt_as_nop_flag[%0d] got %b want 0", i, halted); else passed++;
        end
`endif
    endtask

    task automatic test_reset_mid_wc();
        int exp_st[5];
        exp_st = '{0, 1, 2, 3, 4};
        opcode = 4'd0; mem_rdy = 1'b1; io_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            total++; if (state !== 4'(exp_st[i])) $display("FAIL abort_lead_state[%0d] got %0d want %0d", i, state, exp_st[i]); else passed++;
        end
        total++; if (wrmem !== 1'b1) $display("FAIL abort_in_wc got wrmem=%b want 1", wrmem); else passed++;
        #1 rst = 1'b1;
        #1;
        total++; if (all_outs !== 12'd0) $display("FAIL abort_async_outs got %h want 000", all_outs); else passed++;
        total++; if (state !== 4'd0) $display("FAIL abort_async_state got %0d want 0", state); else passed++;
        @(negedge clk);
        total++; if (all_outs !== 12'd0) $display("FAIL abort_held_outs got %h want 000", all_outs); else passed++;
        rst = 1'b0; mem_rdy = 1'b0;
        #1;
        total++; if (enmem !== 1'b1 || enir !== 1'b1) $display("FAIL abort_refetch got enmem=%b enir=%b want 1 1", enmem, enir); else passed++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (state !== 4'd0) $display("FAIL abort_idle_state[%0d] got %0d want 0", i, state); else passed++;
            total++; if (enpc !== 1'b0 || wrmem !== 1'b0) $display("FAIL abort_no_commit[%0d] got enpc=%b wrmem=%b want 0 0", i, enpc, wrmem); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_sum();
        test_res_stall();
        test_out();
        test_mov();
        test_nop(4'd6);
        test_nop(4'd9);
        test_halt();
        test_reset_mid_wc();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have parameter OPW, default 3, meaning opcode width in bits (legal 3..6).
REQ-002 The block SHALL have parameter SELW, default 2, meaning datapath mux-select width in bits (legal 2..4).
REQ-003 The block SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port opcode  input  OPW  instruction opcode from the IR.
REQ-006 The block SHALL have port mem_rdy  input  1  memory access complete this cycle.
REQ-007 The block SHALL have port io_ack  input  1  output device accepted data this cycle.
REQ-008 The block SHALL have ports enmem, wrmem, enir, enrop1, enrop2, enrio, enpc  output  1 each  memory enable, memory write, IR load, operand-1 load, operand-2 load, IO-register load, PC increment.
REQ-009 The block SHALL have port seloper  output  2  ALU op: 00 add, 01 sub, 10 and, 11 or.
REQ-010 The block SHALL have port selmux  output  SELW  address/data mux select, zero-extended.
REQ-011 The block SHALL have ports halted  output  1  core stopped, and state  output  4  current state code, for debug.

Function
REQ-012 Opcodes SHALL be: 0 SUM, 1 RES, 2 MOV, 3 OUT, 4 AND, 5 OR, 6 NOP, 7 HALT; any value >=8 decodes as NOP.
REQ-013 States and codes SHALL be: F=0, D=1, OP1=2, OP2=3, WC=4, GA=5, GB=6, OA=7, PC=8, H=9; codes 10..15 go to F on the next edge.
REQ-014 Outputs SHALL be Moore (state-decoded only), except that enir and enpc do not depend on inputs either.
REQ-015 F: enmem=1, enir=1, selmux=0; hold until mem_rdy=1, then go to D.
REQ-016 D: all enables 0; latch opcode into an internal register op_q; next state: SUM/RES/AND/OR->OP1, MOV->GA, OUT->OA, NOP->PC, HALT->H (see REQ-027).
REQ-017 OP1: enmem=1, enrop1=1, selmux=1; hold until mem_rdy, then go to OP2.
REQ-018 OP2: enmem=1, enrop2=1, selmux=2, seloper from op_q (SUM 00, RES 01, AND 10, OR 11); hold until mem_rdy, then go to WC.
REQ-019 WC: enmem=1, wrmem=1, selmux=3, seloper held as in OP2; hold until mem_rdy, then go to PC.
REQ-020 GA: enmem=1, enrop1=1, selmux=1; then GB: enmem=1, wrmem=1, selmux=2; each holds until mem_rdy.
REQ-021 OA: enrio=1, selmux=1; hold until io_ack=1, then go to PC.
REQ-022 PC: enpc=1 for exactly one cycle, then F.
REQ-023 All outputs not listed for a state SHALL be 0, and seloper SHALL be 00 outside OP2/WC.
REQ-024 Latency with mem_rdy=io_ack=1 SHALL be: SUM/RES/AND/OR 6 cycles, MOV 5, OUT 4, NOP 3 (F through PC inclusive).
REQ-025 Opcode changes after D SHALL NOT affect the current instruction; only op_q is used.

Reset
REQ-026 While rst=1 the block SHALL hold state=F and op_q=0, and all outputs SHALL be 0, including enmem/enir/halted; the first edge with rst=0 begins fetch; rst asserted mid-instruction SHALL abort it immediately with no further enpc or wrmem.

Configuration
REQ-027 With macro CTRL_HALT_EN defined, HALT SHALL enter H, where all enables are 0 and halted=1 until reset; without it, opcode 7 SHALL decode as NOP, state H SHALL be unreachable and halted SHALL be tied 0.

Verification
REQ-028 SUM, mem_rdy=1 constant -> state sequence 0,1,2,3,4,8,0; enpc high exactly one cycle; seloper=00 in OP2/WC.
REQ-029 RES with mem_rdy low 3 cycles in OP2 -> OP2 held 4 cycles with enrop2=1 and seloper=01, then WC.
REQ-030 OUT with io_ack asserted 2 cycles after entering OA -> enrio high 3 cycles, then PC, then F.
REQ-031 Opcode 9 (OPW=4) -> sequence 0,1,8,0; no enmem in D or PC.
REQ-032 rst pulsed during WC -> outputs 0 asynchronously, state=0; after release, enmem=enir=1 and no enpc for the aborted instruction.
REQ-033 HALT with CTRL_HALT_EN -> state 9, halted=1 for 20+ cycles; without it -> NOP timing (3 cycles), halted=0.
